// File: rtl/apu_noise_control.sv
// APU noise channel register front-end: $400C-$400F decode, envelope and length counter.
// Optional LFSR short-mode select is enabled by defining APU_NOISE_SHORT_MODE_EN.
`timescale 1ns/1ps

module apu_noise_control (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_reg_wr_stb,
    input  logic [1:0]  i_reg_addr,
    input  logic [7:0]  i_reg_data,
    input  logic        i_enable,
    input  logic        i_quarter_frame_stb,
    input  logic        i_half_frame_stb,
    output logic [11:0] o_timer_period,
    output logic        o_period_load_stb,
    output logic        o_mode,
    output logic [3:0]  o_volume,
    output logic        o_length_active
);

    localparam logic [1:0] ADDR_ENV    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_LENGTH = 2'd3;

    function automatic logic [11:0] f_period(input logic [3:0] idx);
        case (idx)
            4'd0:    f_period = 12'd4;
            4'd1:    f_period = 12'd8;
            4'd2:    f_period = 12'd16;
            4'd3:    f_period = 12'd32;
            4'd4:    f_period = 12'd64;
            4'd5:    f_period = 12'd96;
            4'd6:    f_period = 12'd128;
            4'd7:    f_period = 12'd160;
            4'd8:    f_period = 12'd202;
            4'd9:    f_period = 12'd254;
            4'd10:   f_period = 12'd380;
            4'd11:   f_period = 12'd508;
            4'd12:   f_period = 12'd762;
            4'd13:   f_period = 12'd1016;
            4'd14:   f_period = 12'd2034;
            default: f_period = 12'd4068;
        endcase
    endfunction

    function automatic logic [7:0] f_length(input logic [4:0] idx);
        case (idx)
            5'd0:    f_length = 8'd10;
            5'd1:    f_length = 8'd254;
            5'd2:    f_length = 8'd20;
            5'd3:    f_length = 8'd2;
            5'd4:    f_length = 8'd40;
            5'd5:    f_length = 8'd4;
            5'd6:    f_length = 8'd80;
            5'd7:    f_length = 8'd6;
            5'd8:    f_length = 8'd160;
            5'd9:    f_length = 8'd8;
            5'd10:   f_length = 8'd60;
            5'd11:   f_length = 8'd10;
            5'd12:   f_length = 8'd14;
            5'd13:   f_length = 8'd12;
            5'd14:   f_length = 8'd26;
            5'd15:   f_length = 8'd14;
            5'd16:   f_length = 8'd12;
            5'd17:   f_length = 8'd16;
            5'd18:   f_length = 8'd24;
            5'd19:   f_length = 8'd18;
            5'd20:   f_length = 8'd48;
            5'd21:   f_length = 8'd20;
            5'd22:   f_length = 8'd96;
            5'd23:   f_length = 8'd22;
            5'd24:   f_length = 8'd192;
            5'd25:   f_length = 8'd24;
            5'd26:   f_length = 8'd72;
            5'd27:   f_length = 8'd26;
            5'd28:   f_length = 8'd16;
            5'd29:   f_length = 8'd28;
            5'd30:   f_length = 8'd32;
            default: f_length = 8'd30;
        endcase
    endfunction

    logic w_wr_env;
    logic w_wr_period;
    logic w_wr_length;
    logic [3:0] w_volume;

    logic       r_loop;
    logic       r_const;
    logic [3:0] r_vol;
    logic [3:0] r_period_idx;
    logic       r_period_wr;
    logic [7:0] r_length;
    logic       r_start;
    logic [3:0] r_decay;
    logic [3:0] r_divider;

    logic [11:0] r_timer_period_q;
    logic        r_period_load_q;
    logic [3:0]  r_volume_q;
    logic        r_length_active_q;

    assign w_wr_env    = i_reg_wr_stb && (i_reg_addr == ADDR_ENV);
    assign w_wr_period = i_reg_wr_stb && (i_reg_addr == ADDR_PERIOD);
    assign w_wr_length = i_reg_wr_stb && (i_reg_addr == ADDR_LENGTH);

    // NOTE: all state updates are non-blocking, so any event on the same edge sees pre-write values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loop  <= 1'b0;
            r_const <= 1'b0;
            r_vol   <= 4'd0;
        end else if (w_wr_env) begin
            r_loop  <= i_reg_data[5];
            r_const <= i_reg_data[4];
            r_vol   <= i_reg_data[3:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period_idx <= 4'd0;
            r_period_wr  <= 1'b0;
        end else begin
            r_period_wr <= w_wr_period;
            if (w_wr_period) begin
                r_period_idx <= i_reg_data[3:0];
            end
        end
    end

    // Channel disable overrides a same-cycle load; a load overrides a same-cycle decrement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_length <= 8'd0;
        end else if (!i_enable) begin
            r_length <= 8'd0;
        end else if (w_wr_length) begin
            r_length <= f_length(i_reg_data[7:3]);
        end else if (i_half_frame_stb && !r_loop && (r_length != 8'd0)) begin
            r_length <= r_length - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start <= 1'b0;
        end else if (w_wr_length) begin
            r_start <= 1'b1;
        end else if (i_quarter_frame_stb) begin
            r_start <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_decay   <= 4'd0;
            r_divider <= 4'd0;
        end else if (i_quarter_frame_stb) begin
            if (r_start) begin
                r_decay   <= 4'hF;
                r_divider <= r_vol;
            end else if (r_divider == 4'd0) begin
                r_divider <= r_vol;
                if (r_decay != 4'd0) begin
                    r_decay <= r_decay - 4'd1;
                end else if (r_loop) begin
                    r_decay <= 4'hF;
                end
            end else begin
                r_divider <= r_divider - 4'd1;
            end
        end
    end

    assign w_volume = (r_length == 8'd0) ? 4'd0 : (r_const ? r_vol : r_decay);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer_period_q  <= 12'd4;
            r_period_load_q   <= 1'b0;
            r_volume_q        <= 4'd0;
            r_length_active_q <= 1'b0;
        end else begin
            r_timer_period_q  <= f_period(r_period_idx);
            r_period_load_q   <= r_period_wr;
            r_volume_q        <= w_volume;
            r_length_active_q <= (r_length != 8'd0);
        end
    end

`ifdef APU_NOISE_SHORT_MODE_EN
    logic r_mode;
    logic r_mode_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode   <= 1'b0;
            r_mode_q <= 1'b0;
        end else begin
            if (w_wr_period) begin
                r_mode <= i_reg_data[7];
            end
            r_mode_q <= r_mode;
        end
    end

    assign o_mode = r_mode_q;
`else
    assign o_mode = 1'b0;
`endif

    assign o_timer_period    = r_timer_period_q;
    assign o_period_load_stb = r_period_load_q;
    assign o_volume          = r_volume_q;
    assign o_length_active   = r_length_active_q;

endmodule

// File: tb/tb_apu_noise_control.sv
// Scoreboard bench for apu_noise_control: stimulus pushes expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_apu_noise_control;

`ifdef APU_NOISE_SHORT_MODE_EN
    localparam logic EXP_SHORT = 1'b1;
`else
    localparam logic EXP_SHORT = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic        i_reg_wr_stb;
    logic [1:0]  i_reg_addr;
    logic [7:0]  i_reg_data;
    logic        i_enable;
    logic        i_quarter_frame_stb;
    logic        i_half_frame_stb;
    logic [11:0] o_timer_period;
    logic        o_period_load_stb;
    logic        o_mode;
    logic [3:0]  o_volume;
    logic        o_length_active;

    apu_noise_control dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_reg_wr_stb        (i_reg_wr_stb),
        .i_reg_addr          (i_reg_addr),
        .i_reg_data          (i_reg_data),
        .i_enable            (i_enable),
        .i_quarter_frame_stb (i_quarter_frame_stb),
        .i_half_frame_stb    (i_half_frame_stb),
        .o_timer_period      (o_timer_period),
        .o_period_load_stb   (o_period_load_stb),
        .o_mode              (o_mode),
        .o_volume            (o_volume),
        .o_length_active     (o_length_active)
    );

    typedef struct packed {
        logic [11:0] period;
        logic        mode;
        logic [3:0]  vol;
        logic        act;
    } status_t;

    typedef struct packed {
        logic [11:0] period;
        logic        mode;
    } load_t;

    status_t st_q[$];
    string   st_name_q[$];
    load_t   ld_q[$];
    string   ld_name_q[$];

    int   total = 0;
    int   bad   = 0;
    logic chk_req = 1'b0;

    status_t mon_s;
    load_t   mon_l;
    string   mon_n;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: status snapshots on request, period loads whenever the DUT pulses its strobe.
    always @(negedge i_clk) begin
        if (chk_req) begin
            if (st_q.size() == 0) begin
                check("status_queue_nonempty", st_q.size(), 1);
            end else begin
                mon_s = st_q.pop_front();
                mon_n = st_name_q.pop_front();
                check({mon_n, ".period"}, o_timer_period, mon_s.period);
                check({mon_n, ".mode"}, o_mode, mon_s.mode);
                check({mon_n, ".volume"}, o_volume, mon_s.vol);
                check({mon_n, ".active"}, o_length_active, mon_s.act);
            end
        end
        if (o_period_load_stb) begin
            if (ld_q.size() == 0) begin
                check("unexpected_period_load", ld_q.size(), 1);
            end else begin
                mon_l = ld_q.pop_front();
                mon_n = ld_name_q.pop_front();
                check({mon_n, ".load_period"}, o_timer_period, mon_l.period);
                check({mon_n, ".load_mode"}, o_mode, mon_l.mode);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        i_reg_wr_stb = 1'b1;
        i_reg_addr   = a;
        i_reg_data   = d;
        cyc(1);
        i_reg_wr_stb = 1'b0;
    endtask

    task automatic wr_period(input string nm, input logic [7:0] d,
                             input logic [11:0] p, input logic m);
        load_t l;
        l.period = p;
        l.mode   = m;
        ld_q.push_back(l);
        ld_name_q.push_back(nm);
        wr(2'd2, d);
    endtask

    task automatic qf(input int n);
        repeat (n) begin
            i_quarter_frame_stb = 1'b1;
            cyc(1);
            i_quarter_frame_stb = 1'b0;
        end
    endtask

    task automatic hf(input int n);
        repeat (n) begin
            i_half_frame_stb = 1'b1;
            cyc(1);
            i_half_frame_stb = 1'b0;
        end
    endtask

    task automatic push_status(input string nm, input logic [11:0] p, input logic m,
                               input logic [3:0] v, input logic a);
        status_t s;
        s.period = p;
        s.mode   = m;
        s.vol    = v;
        s.act    = a;
        st_q.push_back(s);
        st_name_q.push_back(nm);
    endtask

    task automatic status(input string nm, input logic [11:0] p, input logic m,
                          input logic [3:0] v, input logic a);
        cyc(2);
        push_status(nm, p, m, v, a);
        chk_req = 1'b1;
        cyc(1);
        chk_req = 1'b0;
    endtask

    initial begin
        i_rst_n             = 1'b1;
        i_reg_wr_stb        = 1'b0;
        i_reg_addr          = 2'd0;
        i_reg_data          = 8'd0;
        i_enable            = 1'b0;
        i_quarter_frame_stb = 1'b0;
        i_half_frame_stb    = 1'b0;
        #2 i_rst_n = 1'b0;

        // Reset values while reset is held
        status("reset", 12'd4, 1'b0, 4'd0, 1'b0);
        i_rst_n = 1'b1;
        cyc(2);

        // Constant volume 15, length index 1 = 254, then run it out
        i_enable = 1'b1;
        wr(2'd0, 8'h1F);
        wr(2'd3, 8'h08);
        status("len254_loaded", 12'd4, 1'b0, 4'd15, 1'b1);
        hf(253);
        status("len254_minus253", 12'd4, 1'b0, 4'd15, 1'b1);
        hf(1);
        status("len254_expired", 12'd4, 1'b0, 4'd0, 1'b0);
        hf(1);
        status("len_saturates", 12'd4, 1'b0, 4'd0, 1'b0);

        // Envelope decay with V=2: 15 on first QF, then -1 every 3rd QF
        wr(2'd0, 8'h02);
        wr(2'd3, 8'h00);
        qf(1);
        status("env_start", 12'd4, 1'b0, 4'd15, 1'b1);
        qf(3);
        status("env_first_step", 12'd4, 1'b0, 4'd14, 1'b1);
        qf(42);
        status("env_reach_zero", 12'd4, 1'b0, 4'd0, 1'b1);
        qf(3);
        status("env_hold_zero", 12'd4, 1'b0, 4'd0, 1'b1);
        wr(2'd0, 8'h22);
        qf(3);
        status("env_loop_wrap", 12'd4, 1'b0, 4'd15, 1'b1);

        // Period table and mode bit
        wr_period("period_8D", 8'h8D, 12'd1016, EXP_SHORT);
        status("period_8D", 12'd1016, EXP_SHORT, 4'd15, 1'b1);
        wr_period("period_0F", 8'h0F, 12'd4068, 1'b0);
        status("period_0F", 12'd4068, 1'b0, 4'd15, 1'b1);
        wr_period("period_08", 8'h08, 12'd202, 1'b0);
        wr(2'd1, 8'hFF);
        status("addr1_ignored", 12'd202, 1'b0, 4'd15, 1'b1);

        // Channel disable, write while disabled, load beating a same-cycle decrement
        wr(2'd0, 8'h1F);
        wr(2'd3, 8'h08);
        status("note_on", 12'd202, 1'b0, 4'd15, 1'b1);
        i_enable = 1'b0;
        status("disabled", 12'd202, 1'b0, 4'd0, 1'b0);
        wr(2'd3, 8'h08);
        status("write_while_disabled", 12'd202, 1'b0, 4'd0, 1'b0);
        i_enable = 1'b1;
        cyc(1);
        i_reg_wr_stb     = 1'b1;
        i_reg_addr       = 2'd3;
        i_reg_data       = 8'hF8;
        i_half_frame_stb = 1'b1;
        cyc(1);
        i_reg_wr_stb     = 1'b0;
        i_half_frame_stb = 1'b0;
        hf(29);
        status("load_wins_29", 12'd202, 1'b0, 4'd15, 1'b1);
        hf(1);
        status("load_wins_30", 12'd202, 1'b0, 4'd0, 1'b0);

        // Async reset mid-decay, checked before any further clock edge
        wr(2'd0, 8'h02);
        wr(2'd3, 8'h00);
        qf(2);
        status("pre_reset_decay", 12'd202, 1'b0, 4'd15, 1'b1);
        push_status("async_reset", 12'd4, 1'b0, 4'd0, 1'b0);
        chk_req = 1'b1;
        #1 i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        chk_req = 1'b0;
        i_rst_n = 1'b1;
        cyc(1);
        wr(2'd3, 8'h08);
        status("after_reset_resume", 12'd4, 1'b0, 4'd0, 1'b1);

        cyc(4);
        check("pending_status", st_q.size(), 0);
        check("pending_loads", ld_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
